// File: rtl/poly_lane_alu_if.sv
// Bus bundle for poly_lane_alu: request fields, RAM read port and RAM write port.
interface poly_lane_alu_if #(
   parameter int LANES  = 8,
   parameter int COEF_W = 12,
   parameter int ADDR_W = 8
) ();
   logic                      start;
   logic [1:0]                mode;
   logic [ADDR_W-1:0]         r_start_offset_A;
   logic [ADDR_W-1:0]         r_start_offset_B;
   logic [ADDR_W-1:0]         w_data_addr_offset;
   logic [LANES*COEF_W-1:0]   r_data;
   logic [ADDR_W-1:0]         r_data_addr;
   logic [LANES*COEF_W-1:0]   w_data;
   logic [ADDR_W-1:0]         w_data_addr;
   logic                      w_data_en;
   logic                      busy;
   logic                      last_cycle;

   modport master (
      output start, mode, r_start_offset_A, r_start_offset_B, w_data_addr_offset, r_data,
      input  r_data_addr, w_data, w_data_addr, w_data_en, busy, last_cycle
   );

   modport slave (
      input  start, mode, r_start_offset_A, r_start_offset_B, w_data_addr_offset, r_data,
      output r_data_addr, w_data, w_data_addr, w_data_en, busy, last_cycle
   );
endinterface

// File: rtl/poly_lane_alu.sv
// Streaming lane-wise modular ADD/SUB/COPY/NEG over two RAM polynomials.
// Define POLY_LANE_ALU_PIPE_EN to add one register stage before w_data.
module poly_lane_alu #(
   parameter int LANES  = 8,
   parameter int COEF_W = 12,
   parameter int Q      = 3329,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   poly_lane_alu_if.slave  bus
);
   localparam int W     = LANES*COEF_W;
   localparam int CNT_W = (DEPTH > 1) ? $clog2(2*DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(2*DEPTH-1);
   localparam logic [CNT_W-1:0] LAST_WR = CNT_W'(DEPTH-1);
   localparam logic [COEF_W:0]  QX      = (COEF_W+1)'(Q);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_COPY, OP_NEG} op_t;

   state_t             state, state_n;
   op_t                mode_q;
   logic [ADDR_W-1:0]  a_off_q, b_off_q, w_off_q;
   logic [CNT_W-1:0]   rcnt, widx;
   logic [ADDR_W-1:0]  rd_addr, rd_addr_n;
   logic               a_pend, b_pend;
   logic [W-1:0]       a_reg, lane_res;
   logic [W-1:0]       res_data;
   logic [ADDR_W-1:0]  res_addr;
   logic               res_en, res_last;
   logic               last_out;
   logic [COEF_W-1:0]  la, lb;
   logic [COEF_W:0]    sum, dif, tmp;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.start) state_n = RUN;
         RUN:     if (rcnt == LAST_RD) state_n = DRAIN;
         DRAIN:   if (last_out) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Even rcnt is issuing A_i, so the next read is B_i; odd rcnt moves on to A_{i+1}.
   always_comb begin
      if (!rcnt[0]) rd_addr_n = b_off_q + ADDR_W'(rcnt >> 1);
      else          rd_addr_n = a_off_q + ADDR_W'(rcnt >> 1) + ADDR_W'(1);
   end

   always_comb begin
      lane_res = '0;
      la  = '0;
      lb  = '0;
      sum = '0;
      dif = '0;
      tmp = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
         la  = a_reg[j*COEF_W +: COEF_W];
         lb  = bus.r_data[j*COEF_W +: COEF_W];
         sum = {1'b0, la} + {1'b0, lb};
         dif = {1'b0, la} - {1'b0, lb};
         case (mode_q)
            OP_ADD:  tmp = (sum >= QX) ? sum - QX : sum;
            OP_SUB:  tmp = dif[COEF_W] ? dif + QX : dif;
            OP_COPY: tmp = {1'b0, la};
            default: tmp = (la == '0) ? '0 : QX - {1'b0, la};
         endcase
         lane_res[j*COEF_W +: COEF_W] = tmp[COEF_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= OP_ADD;
         a_off_q  <= '0;
         b_off_q  <= '0;
         w_off_q  <= '0;
         rcnt     <= '0;
         widx     <= '0;
         rd_addr  <= '0;
         a_pend   <= 1'b0;
         b_pend   <= 1'b0;
         a_reg    <= '0;
         res_data <= '0;
         res_addr <= '0;
         res_en   <= 1'b0;
         res_last <= 1'b0;
      end else begin
         a_pend <= (state == RUN) && !rcnt[0];
         b_pend <= (state == RUN) &&  rcnt[0];
         if (state == IDLE && bus.start) begin
            mode_q  <= op_t'(bus.mode);
            a_off_q <= bus.r_start_offset_A;
            b_off_q <= bus.r_start_offset_B;
            w_off_q <= bus.w_data_addr_offset;
            rd_addr <= bus.r_start_offset_A;
            rcnt    <= '0;
            widx    <= '0;
         end
         if (state == RUN && rcnt != LAST_RD) begin
            rcnt    <= rcnt + CNT_W'(1);
            rd_addr <= rd_addr_n;
         end
         if (a_pend) a_reg <= bus.r_data;
         res_en   <= b_pend;
         res_last <= b_pend && (widx == LAST_WR);
         if (b_pend) begin
            res_data <= lane_res;
            res_addr <= w_off_q + ADDR_W'(widx);
            widx     <= widx + CNT_W'(1);
         end
      end
   end

`ifdef POLY_LANE_ALU_PIPE_EN
   logic [W-1:0]      out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_addr <= '0;
         out_en   <= 1'b0;
         last_out <= 1'b0;
      end else begin
         out_en   <= res_en;
         last_out <= res_last;
         if (res_en) begin
            out_data <= res_data;
            out_addr <= res_addr;
         end
      end
   end

   assign bus.w_data      = out_data;
   assign bus.w_data_addr = out_addr;
   assign bus.w_data_en   = out_en;
`else
   assign last_out        = res_last;
   assign bus.w_data      = res_data;
   assign bus.w_data_addr = res_addr;
   assign bus.w_data_en   = res_en;
`endif

   assign bus.r_data_addr = rd_addr;
   assign bus.last_cycle  = last_out;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_poly_lane_alu.sv
// Scoreboard bench for poly_lane_alu: expected writes queued at start, checked as they appear.
module tb_poly_lane_alu;
   localparam int LANES  = 8;
   localparam int COEF_W = 12;
   localparam int Q      = 3329;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 8;
   localparam int W      = LANES*COEF_W;
`ifdef POLY_LANE_ALU_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   poly_lane_alu_if #(.LANES(LANES), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

   poly_lane_alu #(
      .LANES(LANES), .COEF_W(COEF_W), .Q(Q), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [W-1:0]      data;
      logic              last;
   } wr_t;

   wr_t               exp_q[$];
   logic [W-1:0]      mem [256];
   int                t0;
   bit                rd_chk;
   logic [ADDR_W-1:0] rd_a, rd_b;
   int                n_tests = 0;
   int                n_fail  = 0;

   // synchronous read RAM; results are not stored, so reads never see DUT writes
   always @(posedge clk) bus.r_data <= mem[bus.r_data_addr];

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [COEF_W-1:0] lane_op(input int m, input int a, input int b);
      int r;
      case (m)
         0:       r = (a + b) % Q;
         1:       r = (a - b + Q) % Q;
         2:       r = a;
         default: r = (Q - a) % Q;
      endcase
      return COEF_W'(r);
   endfunction

   function automatic logic [W-1:0] word_op(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < LANES; k++)
         r[k*COEF_W +: COEF_W] = lane_op(m, int'(a[k*COEF_W +: COEF_W]), int'(b[k*COEF_W +: COEF_W]));
      return r;
   endfunction

   function automatic logic [W-1:0] splat(input int v);
      logic [W-1:0] r;
      for (int k = 0; k < LANES; k++) r[k*COEF_W +: COEF_W] = COEF_W'(v);
      return r;
   endfunction

   function automatic logic [W-1:0] rnd_word();
      logic [W-1:0] r;
      for (int k = 0; k < LANES; k++) r[k*COEF_W +: COEF_W] = COEF_W'($urandom_range(Q-1));
      return r;
   endfunction

   int                mrel;
   wr_t               me;
   logic [ADDR_W-1:0] mexp_addr;

   always @(negedge clk) begin
      mrel = cyc - t0;
      if (rd_chk && mrel >= 1 && mrel <= 2*DEPTH) begin
         if (mrel % 2 == 1) mexp_addr = rd_a + ADDR_W'((mrel - 1) / 2);
         else               mexp_addr = rd_b + ADDR_W'((mrel - 2) / 2);
         check("rd_addr", W'(bus.r_data_addr), W'(mexp_addr));
      end
      if (bus.w_data_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", W'(bus.w_data_en), '0);
         end else begin
            me = exp_q.pop_front();
            check("wr_cycle", W'(mrel), W'(me.cyc));
            check("wr_addr",  W'(bus.w_data_addr), W'(me.addr));
            check("wr_data",  bus.w_data, me.data);
            check("wr_last",  W'(bus.last_cycle), W'(me.last));
         end
      end else if (bus.last_cycle !== 1'b0) begin
         check("last_no_wr", W'(bus.last_cycle), '0);
      end
   end

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_addr"}, W'(bus.r_data_addr), '0);
      check({tag, "_w_data"},  bus.w_data, '0);
      check({tag, "_w_addr"},  W'(bus.w_data_addr), '0);
      check({tag, "_w_en"},    W'(bus.w_data_en), '0);
      check({tag, "_busy"},    W'(bus.busy), '0);
      check({tag, "_last"},    W'(bus.last_cycle), '0);
   endtask

   task automatic push_exp(input int m, input logic [ADDR_W-1:0] aoff,
                           input logic [ADDR_W-1:0] boff, input logic [ADDR_W-1:0] woff);
      wr_t e;
      for (int i = 0; i < DEPTH; i++) begin
         e.cyc  = 2*i + 4 + PIPE;
         e.addr = woff + ADDR_W'(i);
         e.data = word_op(m, mem[aoff + ADDR_W'(i)], mem[boff + ADDR_W'(i)]);
         e.last = (i == DEPTH-1);
         exp_q.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge where busy is seen low (or just after reset).
   task automatic run_op(input int m, input logic [ADDR_W-1:0] aoff, input logic [ADDR_W-1:0] boff,
                         input logic [ADDR_W-1:0] woff, input bit chk_rd, input bit disturb,
                         input bit do_rst);
      int rel;
      bit done;
      push_exp(m, aoff, boff, woff);
      bus.start              = 1'b1;
      bus.mode               = 2'(m);
      bus.r_start_offset_A   = aoff;
      bus.r_start_offset_B   = boff;
      bus.w_data_addr_offset = woff;
      rd_a   = aoff;
      rd_b   = boff;
      rd_chk = chk_rd;
      t0     = cyc;
      done   = 1'b0;
      while (!done) begin
         @(negedge clk);
         rel = cyc - t0;
         if (rel == 1) begin
            bus.start              = 1'b0;
            bus.mode               = ~bus.mode;
            bus.r_start_offset_A   = ~aoff;
            bus.r_start_offset_B   = ~boff;
            bus.w_data_addr_offset = ~woff;
         end
         if (disturb && rel == 10) begin
            bus.start = 1'b1;
            bus.mode  = 2'(m ^ 1);
         end
         if (disturb && rel == 11) bus.start = 1'b0;
         if (do_rst && rel == 20) rst = 1'b1;
         if (do_rst && rel == 21) begin
            check_reset_vals("rst_mid");
            rst = 1'b0;
            exp_q.delete();
            done = 1'b1;
         end else if (rel >= 1 && bus.busy === 1'b0) begin
            check("busy_fall", W'(rel), W'(2*DEPTH + 3 + PIPE));
            done = 1'b1;
         end else if (rel > 4*DEPTH + 20) begin
            check("timeout", W'(rel), W'(2*DEPTH + 3 + PIPE));
            done = 1'b1;
         end
      end
      rd_chk = 1'b0;
      if (!do_rst) check("queue_empty", W'(exp_q.size()), '0);
   endtask

   initial begin
      logic [W-1:0] wv;
      rst                    = 1'b1;
      bus.start              = 1'b0;
      bus.mode               = '0;
      bus.r_start_offset_A   = '0;
      bus.r_start_offset_B   = '0;
      bus.w_data_addr_offset = '0;
      rd_chk = 1'b0;
      t0     = 0;
      for (int a = 0; a < 256; a++) mem[a] = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("por");
      rst = 1'b0;
      @(negedge clk);

      // ADD: A lanes 8i+k, B lanes Q-1
      for (int i = 0; i < DEPTH; i++) begin
         for (int k = 0; k < LANES; k++) wv[k*COEF_W +: COEF_W] = COEF_W'(8*i + k);
         mem[i]      = wv;
         mem[64 + i] = splat(Q-1);
      end
      run_op(0, 8'd0, 8'd64, 8'd128, 1'b1, 1'b0, 1'b0);

      // SUB 5-10
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]      = splat(5);
         mem[64 + i] = splat(10);
      end
      run_op(1, 8'd0, 8'd64, 8'd128, 1'b0, 1'b0, 1'b0);

      // ADD (Q-1)+(Q-1)
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]      = splat(Q-1);
         mem[64 + i] = splat(Q-1);
      end
      run_op(0, 8'd0, 8'd64, 8'd128, 1'b0, 1'b0, 1'b0);

      // NEG with 0, 1, Q-1, 1664 in the low lanes
      for (int i = 0; i < DEPTH; i++) begin
         wv = rnd_word();
         wv[0*COEF_W +: COEF_W] = COEF_W'(0);
         wv[1*COEF_W +: COEF_W] = COEF_W'(1);
         wv[2*COEF_W +: COEF_W] = COEF_W'(Q-1);
         wv[3*COEF_W +: COEF_W] = COEF_W'(1664);
         mem[i]      = wv;
         mem[64 + i] = rnd_word();
      end
      run_op(3, 8'd0, 8'd64, 8'd128, 1'b0, 1'b0, 1'b0);

      // COPY with arbitrary B
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]      = rnd_word();
         mem[64 + i] = rnd_word();
      end
      run_op(2, 8'd0, 8'd64, 8'd128, 1'b0, 1'b0, 1'b0);

      // address wrap on A and on the result
      for (int i = 0; i < DEPTH; i++) begin
         mem[8'(250 + i)] = rnd_word();
         mem[100 + i]     = rnd_word();
      end
      run_op(1, 8'd250, 8'd100, 8'd240, 1'b1, 1'b0, 1'b0);

      // start/mode disturbance mid-run, then a back-to-back start
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]      = rnd_word();
         mem[64 + i] = rnd_word();
      end
      run_op(1, 8'd0, 8'd64, 8'd128, 1'b0, 1'b1, 1'b0);
      run_op(0, 8'd0, 8'd64, 8'd160, 1'b1, 1'b0, 1'b0);

      // reset in cycle 20, then a full run
      run_op(0, 8'd0, 8'd64, 8'd128, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]      = rnd_word();
         mem[64 + i] = rnd_word();
      end
      run_op(0, 8'd0, 8'd64, 8'd128, 1'b1, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/poly_lane_alu.md
# poly_lane_alu

Parametrised streaming coefficient-wise ALU for the polynomial RAM used by the NTT datapath. It generalises the fixed-width ADDSUB path: lane count, coefficient width, modulus, polynomial depth and address width are all parameters, and it adds COPY and NEG modes. It reads polynomial A and polynomial B word by word through the shared single read port, applies a per-lane modular operation, and writes the result polynomial back through the write port. It sits beside `ntt_processor` on the same RAM, and the top-level arbiter selects between the two.

## Interface
- LANES, 8: coefficients per RAM word.
- COEF_W, 12: bits per coefficient.
- Q, 3329: modulus; must satisfy Q < 2^COEF_W.
- DEPTH, 32: RAM words per polynomial.
- ADDR_W, 8: RAM address width.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  0 ADD, 1 SUB, 2 COPY, 3 NEG; latched at start.
- r_start_offset_A  in  ADDR_W  base address of A; latched at start.
- r_start_offset_B  in  ADDR_W  base address of B; latched at start.
- w_data_addr_offset  in  ADDR_W  base address of the result; latched at start.
- r_data  in  LANES*COEF_W  RAM read data, valid one cycle after r_data_addr.
- r_data_addr  out  ADDR_W  RAM read address.
- w_data  out  LANES*COEF_W  RAM write data.
- w_data_addr  out  ADDR_W  RAM write address.
- w_data_en  out  1  RAM write strobe.
- busy  out  1  high from the first cycle after start is accepted until done.
- last_cycle  out  1  one-cycle pulse coincident with the final write.

## Operation
- Lane j occupies bits [j*COEF_W +: COEF_W] on r_data and w_data.
- FSM states:
  - IDLE: start=1 goes to RUN.
  - RUN: issues reads. After 2*DEPTH read cycles it goes to DRAIN.
  - DRAIN: waits until the final write. On the last_cycle pulse it returns to IDLE.
- RUN addressing:
  - Odd cycles issue A_i at r_start_offset_A+i.
  - Even cycles issue B_i at r_start_offset_B+i.
  - i runs from 0 to DEPTH-1.
- Read data from A_i is captured in an A register. B_i data is combined with it lane-wise.
- Lane operations, with inputs in [0,Q):
  - ADD: a+b, minus Q if the sum is ≥Q.
  - SUB: a-b, plus Q if the difference is negative.
  - COPY: a.
  - NEG: 0 if a=0, otherwise Q-a.
- Intermediate width is COEF_W+1, using a single conditional correction. Results for inputs ≥Q are not specified.
- The result for word i is written at w_data_addr_offset+i.
- All address sums wrap modulo 2^ADDR_W.
- B is read in every mode, so timing does not depend on mode.
- start is ignored while busy=1. Input changes after the start cycle have no effect.
- rst at any time:
  - FSM returns to IDLE.
  - Pending writes are discarded.
  - All outputs take their reset values on the next cycle.

## Timing
- Reset values: r_data_addr=0, w_data=0, w_data_addr=0, w_data_en=0, busy=0, last_cycle=0.
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. From cycle 1:
  - r_data_addr = A_off+i in cycle 2i+1.
  - r_data_addr = B_off+i in cycle 2i+2.
  - A_i data is captured at the end of cycle 2i+2.
  - The result is registered at the end of cycle 2i+3.
  - w_data_en=1 with w_data and w_data_addr valid in cycle 2i+4. This is +1 with the pipe stage.
- Writes are one-cycle strobes with one idle cycle between them.
- The final write is in cycle 2*DEPTH+2 (66 at defaults). last_cycle=1 in that cycle.
- busy=0 and IDLE from cycle 2*DEPTH+3. A new start is accepted in that cycle.
- r_data_addr holds its last value when not reading.
- w_data holds its last value when w_data_en=0.
- When write and read addresses alias, the write does not affect operands already read. The caller owns RAM hazards.

## Configuration
- POLY_LANE_ALU_PIPE_EN defined:
  - One extra register stage is inserted between the lane arithmetic and w_data.
  - All write-side timings and last_cycle shift by +1 cycle. The final write is in cycle 2*DEPTH+3.
  - busy falls one cycle later.
- POLY_LANE_ALU_PIPE_EN undefined: timing is exactly as specified above.

## Test plan
- ADD, defaults, A word i lanes = {8i..8i+7}, B lanes = 3328:
  - w_data lanes = 8i+k-1 mod 3329.
  - Lane value 0 yields 3328.
  - 32 writes, last_cycle in cycle 66.
- SUB, A lanes = 5, B lanes = 10 -> all lanes 3324. ADD with 3328+3328 -> 3327.
- NEG with A lanes {0,1,3328,1664,…} -> {0,3328,1,1665,…}. COPY returns A unchanged whatever B holds.
- Wrap: r_start_offset_A=250, DEPTH=32.
  - Read addresses run 250..255, then 0..25.
  - With w_data_addr_offset=240, writes run 240..255, then 0..15.
- start reasserted at cycle 10 and a mode change mid-run -> ignored. Output matches the original mode. The next start is accepted in cycle 67.
- rst=1 in cycle 20:
  - Cycle 21: w_data_en=0 and busy=0, and all outputs are at reset values.
  - A later start runs a complete, correct 32-word operation.
  - Repeat with POLY_LANE_ALU_PIPE_EN defined: final write and last_cycle in cycle 67.
